// File: rtl/shared_reg_arbiter_if.sv
// Requester-side bus of shared_reg_arbiter: request/data in, grant/ack/register view out.
interface shared_reg_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 8
);
  localparam int unsigned OW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] wdata;
  logic [NUM_REQ-1:0]       gnt;
  logic [NUM_REQ-1:0]       ack;
  logic [WIDTH-1:0]         q_out;
  logic [WIDTH-1:0]         q_bar;
  logic                     busy;
  logic [OW-1:0]            owner;

  modport master (
    output req, wdata,
    input  gnt, ack, q_out, q_bar, busy, owner
  );

  modport slave (
    input  req, wdata,
    output gnt, ack, q_out, q_bar, busy, owner
  );
endinterface

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbitrated write controller for a shared register (IDLE -> GRANT -> WRITE).
// Define SHARED_REG_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead.
module shared_reg_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  shared_reg_arbiter_if.slave bus
);
  localparam int unsigned OW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, GRANT, WRITE} state_t;

  state_t             state, state_nxt;
  logic [NUM_REQ-1:0] gnt_r, gnt_nxt;
  logic [NUM_REQ-1:0] ack_r, ack_nxt;
  logic [WIDTH-1:0]   q_r, q_nxt;
  logic [OW-1:0]      owner_r, owner_nxt;
  logic [OW-1:0]      win;
  logic [NUM_REQ-1:0] rot;
  logic               found;
  logic               req_own;
  logic [WIDTH-1:0]   wsel;

`ifndef SHARED_REG_ARB_FIXED_PRIO_EN
  logic [OW-1:0] ptr, ptr_nxt;

  function automatic logic [OW-1:0] wrap_add(input logic [OW-1:0] base, input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return OW'(s);
  endfunction
`endif

  // Requests are rotated so that bit 0 of rot is the highest-priority candidate.
  always_comb begin
    found = 1'b0;
    win   = '0;
`ifdef SHARED_REG_ARB_FIXED_PRIO_EN
    rot = bus.req;
`else
    rot = NUM_REQ'({bus.req, bus.req} >> ptr);
`endif
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
`ifdef SHARED_REG_ARB_FIXED_PRIO_EN
        win = OW'(k);
`else
        win = wrap_add(ptr, k);
`endif
      end
    end
  end

  always_comb begin
    wsel    = '0;
    req_own = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (owner_r == OW'(i)) begin
        wsel    = bus.wdata[i*WIDTH +: WIDTH];
        req_own = bus.req[i];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt_r;
    ack_nxt   = ack_r;
    q_nxt     = q_r;
    owner_nxt = owner_r;
`ifndef SHARED_REG_ARB_FIXED_PRIO_EN
    ptr_nxt   = ptr;
`endif
    case (state)
      IDLE: begin
        if (found) begin
          owner_nxt = win;
          gnt_nxt   = NUM_REQ'(1) << win;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        gnt_nxt = '0;
`ifndef SHARED_REG_ARB_FIXED_PRIO_EN
        ptr_nxt = wrap_add(owner_r, 1);
`endif
        if (req_own) begin
          q_nxt     = wsel;
          ack_nxt   = NUM_REQ'(1) << owner_r;
          state_nxt = WRITE;
        end else begin
          state_nxt = IDLE;
        end
      end
      WRITE: begin
        ack_nxt   = '0;
        state_nxt = IDLE;
      end
      default: begin
        gnt_nxt   = '0;
        ack_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      gnt_r   <= '0;
      ack_r   <= '0;
      q_r     <= '0;
      owner_r <= '0;
`ifndef SHARED_REG_ARB_FIXED_PRIO_EN
      ptr     <= '0;
`endif
    end else begin
      state   <= state_nxt;
      gnt_r   <= gnt_nxt;
      ack_r   <= ack_nxt;
      q_r     <= q_nxt;
      owner_r <= owner_nxt;
`ifndef SHARED_REG_ARB_FIXED_PRIO_EN
      ptr     <= ptr_nxt;
`endif
    end
  end

  assign bus.gnt   = gnt_r;
  assign bus.ack   = ack_r;
  assign bus.q_out = q_r;
  assign bus.q_bar = ~q_r;
  assign bus.busy  = (state != IDLE);
  assign bus.owner = owner_r;
endmodule
